voting_ballot_collector: RTL and testbench
==========================================

Name: voting_ballot_collector

Overview:
- Voter-side front end for the 4-voter, 2-bit-ballot combinational tally.
- Accepts ballots one at a time over a valid/ready handshake and tracks which voters have voted.
- Packs the ballots into the 8-bit ballot word the tally consumes, then hands the complete round downstream over a second valid/ready handshake.
- Sits between the voter interface and the tally inputs x0..x7.

Parameters:
- NUM_VOTERS, 4, number of ballot slots; fixed at 4 to match the tally input width.
- BALLOT_W, 2, bits per ballot.
- ID_W, 2, voter-id width (clog2 of NUM_VOTERS).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, ballot offered.
- in_ready, output, 1, collector can accept a ballot.
- in_voter_id, input, ID_W, slot index of the ballot.
- in_choice, input, BALLOT_W, ballot value.
- close_req, input, 1, one-cycle pulse; closes the round early.
- dup_err, output, 1, one-cycle pulse on a duplicate vote.
- out_valid, output, 1, packed round available.
- out_ready, input, 1, downstream (tally) accepts the round.
- out_ballots, output, NUM_VOTERS*BALLOT_W, packed ballots; voter k at bits [2k+1:2k], i.e. tally x(2k+1),x(2k).
- out_voted_mask, output, NUM_VOTERS, bit k set if voter k actually voted.

Behaviour:
- Reset values: state=COLLECT, in_ready=1, out_valid=0, out_ballots=0, out_voted_mask=0, dup_err=0, internal ballot register and mask cleared.
- COLLECT state:
  - in_ready=1 and out_valid=0.
  - Accept: in_valid&&in_ready on a rising edge.
  - New voter (mask[id]=0): write the ballot into slot id; set mask[id].
  - Duplicate (mask[id]=1): discard the ballot; the original is kept; dup_err=1 on the next cycle for exactly one cycle. The handshake still completes, so the ballot is consumed.
  - Transition to PRESENT on the edge where the mask becomes all-ones (the 4th distinct voter is accepted).
  - close_req=1 also transitions to PRESENT, even with a partial mask. Missing slots present as 2'b00 (abstain encoding).
  - close_req together with an accepted new ballot: the ballot is included, then PRESENT.
  - close_req together with a duplicate: dup_err still pulses.
  - close_req with an empty mask: PRESENT with out_ballots=0 and mask=0. Rounds are never suppressed.
- PRESENT state:
  - in_ready=0 and out_valid=1.
  - out_ballots and out_voted_mask hold stable until out_valid&&out_ready.
  - close_req is ignored.
  - On handshake: next cycle returns to COLLECT, ballot register and mask cleared, out_valid=0, in_ready=1.
  - out_ballots is registered output and is 0 in COLLECT.
- Latency:
  - Completing ballot accepted at cycle t gives out_valid=1 at t+1.
  - out_ready held high gives the round handshake at t+1 and in_ready=1 at t+2.
  - Minimum round period is N+1 cycles for N ballots.
- Boundaries:
  - Out-of-range ids cannot occur (ID_W exact).
  - in_valid while in_ready=0 is ignored; the input is not consumed.
  - rst asserted mid-round discards all partial ballots and any pending round; rst has priority over every other input.

Optional Feature:
- Macro: VOTING_ROUND_SEQ_EN.
- When defined:
  - Adds output round_seq [7:0], reset 0.
  - Increments by 1 on each out handshake, wrapping 255→0.
  - The value presented with a round is the value before the increment.
  - Adds output round_partial [0:0], =1 in PRESENT when the mask is not all-ones, else 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then ballots id0=01, id1=10, id2=11, id3=00 on consecutive cycles with out_ready=1:
  - out_valid=1 one cycle after id3, out_ballots=8'b00_11_10_01, out_voted_mask=4'b1111.
  - in_ready returns to 1 two cycles after id3.
- id2=10, then id2=01 (duplicate), then id0,id1,id3=11:
  - dup_err pulses once after the duplicate.
  - out_ballots=8'b11_10_11_11; slot 2 keeps 10.
- id1=11, then close_req:
  - PRESENT with out_ballots=8'b00_00_11_00 and mask=4'b0010.
  - With VOTING_ROUND_SEQ_EN: round_partial=1.
- Full round presented with out_ready=0 for 5 cycles and in_valid=1 offering id0:
  - out_ballots stable, in_ready=0, no ballot consumed.
  - Handshake on cycle 6, then the id0 ballot is accepted in the new round.
- rst=1 mid-round after 3 ballots:
  - All outputs return to reset values.
  - A subsequent single ballot plus close_req yields mask with only that bit set.
- VOTING_ROUND_SEQ_EN: 257 complete rounds give round_seq 0..255, then 0.

Source files
------------

// File: rtl/voting_ballot_collector_if.sv
// Voter-side and tally-side handshake bundle for the ballot collector.
// Defining VOTING_ROUND_SEQ_EN adds the round_seq / round_partial signals.
interface voting_ballot_collector_if #(
  parameter int NUM_VOTERS = 4,
  parameter int BALLOT_W   = 2,
  parameter int ID_W       = 2
);
  logic                           in_valid;
  logic                           in_ready;
  logic [ID_W-1:0]                in_voter_id;
  logic [BALLOT_W-1:0]            in_choice;
  logic                           close_req;
  logic                           dup_err;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_VOTERS*BALLOT_W-1:0] out_ballots;
  logic [NUM_VOTERS-1:0]          out_voted_mask;
`ifdef VOTING_ROUND_SEQ_EN
  logic [7:0]                     round_seq;
  logic [0:0]                     round_partial;

  modport master (
    output in_valid, in_voter_id, in_choice, close_req, out_ready,
    input  in_ready, dup_err, out_valid, out_ballots, out_voted_mask, round_seq, round_partial
  );
  modport slave (
    input  in_valid, in_voter_id, in_choice, close_req, out_ready,
    output in_ready, dup_err, out_valid, out_ballots, out_voted_mask, round_seq, round_partial
  );
`else
  modport master (
    output in_valid, in_voter_id, in_choice, close_req, out_ready,
    input  in_ready, dup_err, out_valid, out_ballots, out_voted_mask
  );
  modport slave (
    input  in_valid, in_voter_id, in_choice, close_req, out_ready,
    output in_ready, dup_err, out_valid, out_ballots, out_voted_mask
  );
`endif
endinterface

// File: rtl/voting_ballot_collector.sv
// Collects one ballot per voter, packs them into the tally word and presents the round downstream.
// Optional round numbering: define VOTING_ROUND_SEQ_EN.
module voting_ballot_collector #(
  parameter int NUM_VOTERS = 4,
  parameter int BALLOT_W   = 2,
  parameter int ID_W       = 2
) (
  input logic                      clk,
  input logic                      rst,
  voting_ballot_collector_if.slave bus
);
  // state      | meaning
  // ST_COLLECT | accepting ballots, building the round
  // ST_PRESENT | round held on the output until the tally takes it
  typedef enum logic {ST_COLLECT, ST_PRESENT} state_t;

  localparam int WORD_W = NUM_VOTERS * BALLOT_W;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     ballots_q, ballots_d;
  logic [NUM_VOTERS-1:0] mask_q, mask_d;
  logic                  dup_q, dup_d;
  logic                  slot_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      ballots_q <= '0;
      mask_q    <= '0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ballots_q <= ballots_d;
      mask_q    <= mask_d;
      dup_q     <= dup_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ballots_d  = ballots_q;
    mask_d     = mask_q;
    dup_d      = 1'b0;
    slot_taken = mask_q[bus.in_voter_id];
    case (state_q)
      ST_COLLECT: begin
        // A duplicate still completes the handshake; only the first ballot per voter counts.
        if (bus.in_valid && slot_taken) begin
          dup_d = 1'b1;
        end
        if (bus.in_valid && !slot_taken) begin
          mask_d[bus.in_voter_id] = 1'b1;
          for (int k = 0; k < NUM_VOTERS; k++) begin
            if (bus.in_voter_id == ID_W'(k)) begin
              ballots_d[k*BALLOT_W +: BALLOT_W] = bus.in_choice;
            end
          end
        end
        if ((&mask_d) || bus.close_req) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.out_ready) begin
          state_d   = ST_COLLECT;
          ballots_d = '0;
          mask_d    = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  assign bus.in_ready       = (state_q == ST_COLLECT);
  assign bus.out_valid      = (state_q == ST_PRESENT);
  assign bus.out_ballots    = (state_q == ST_PRESENT) ? ballots_q : '0;
  assign bus.out_voted_mask = (state_q == ST_PRESENT) ? mask_q : '0;
  assign bus.dup_err        = dup_q;

`ifdef VOTING_ROUND_SEQ_EN
  logic [7:0] seq_q;

  // Counts completed rounds; the presented value is the pre-increment one.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if ((state_q == ST_PRESENT) && bus.out_ready) begin
      seq_q <= seq_q + 8'd1;
    end
  end

  assign bus.round_seq     = seq_q;
  assign bus.round_partial = 1'((state_q == ST_PRESENT) && !(&mask_q));
`else
  // Round numbering disabled: no extra state or outputs.
`endif
endmodule

// File: tb/tb_voting_ballot_collector.sv
// Randomized and directed checks of voting_ballot_collector against a slot/flag reference model.
module tb_voting_ballot_collector;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  voting_ballot_collector_if #(.NUM_VOTERS(4), .BALLOT_W(2), .ID_W(2)) bus ();

  voting_ballot_collector #(.NUM_VOTERS(4), .BALLOT_W(2), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: one ballot per voter slot, a voted flag per voter, a "round on display" flag.
  bit         m_present;
  logic [1:0] m_slot [NV];
  bit         m_voted [NV];
  bit         m_dup;
  int         m_seq;

  function automatic bit all_voted();
    int n = 0;
    for (int k = 0; k < NV; k++) n += int'(m_voted[k]);
    return n == NV;
  endfunction

  function automatic logic [7:0] exp_word();
    logic [7:0] w = '0;
    if (m_present) for (int k = 0; k < NV; k++) w[2*k +: 2] = m_slot[k];
    return w;
  endfunction

  function automatic logic [3:0] exp_mask();
    logic [3:0] m = '0;
    if (m_present) for (int k = 0; k < NV; k++) m[k] = m_voted[k];
    return m;
  endfunction

  task automatic clear_round();
    m_present = 1'b0;
    for (int k = 0; k < NV; k++) begin
      m_slot[k]  = 2'b00;
      m_voted[k] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [1:0] id, input logic [1:0] ch,
                      input logic cl, input logic ordy, input logic r);
    bus.in_valid    = v;
    bus.in_voter_id = id;
    bus.in_choice   = ch;
    bus.close_req   = cl;
    bus.out_ready   = ordy;
    rst             = r;
    @(posedge clk);
    if (r) begin
      clear_round();
      m_dup = 1'b0;
      m_seq = 0;
    end else if (!m_present) begin
      m_dup = v && m_voted[id];
      if (v && !m_voted[id]) begin
        m_slot[id]  = ch;
        m_voted[id] = 1'b1;
      end
      if (all_voted() || cl) m_present = 1'b1;
    end else begin
      m_dup = 1'b0;
      if (ordy) begin
        clear_round();
        m_seq = (m_seq + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(1, 2, 3, 1, 1, 1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_ballots !== 8'h00) begin errors++; $display("FAIL reset_ballots got %h want 00", bus.out_ballots); end
    checks++; if (bus.out_voted_mask !== 4'h0) begin errors++; $display("FAIL reset_mask got %h want 0", bus.out_voted_mask); end
    checks++; if (bus.dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup got %b want 0", bus.dup_err); end
`ifdef VOTING_ROUND_SEQ_EN
    checks++; if (bus.round_seq !== 8'd0) begin errors++; $display("FAIL reset_seq got %0d want 0", bus.round_seq); end
`endif
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full_round();
    step(1, 0, 2'b01, 0, 1, 0);
    step(1, 1, 2'b10, 0, 1, 0);
    step(1, 2, 2'b11, 0, 1, 0);
    step(1, 3, 2'b00, 0, 1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_ballots !== 8'b00_11_10_01) begin errors++; $display("FAIL full_ballots got %b want 00111001", bus.out_ballots); end
    checks++; if (bus.out_voted_mask !== 4'b1111) begin errors++; $display("FAIL full_mask got %b want 1111", bus.out_voted_mask); end
    step(0, 0, 0, 0, 1, 0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got %b want 0", bus.out_valid); end
  endtask

  task automatic test_duplicate();
    step(1, 2, 2'b10, 0, 0, 0);
    checks++; if (bus.dup_err !== 1'b0) begin errors++; $display("FAIL dup_first got %b want 0", bus.dup_err); end
    step(1, 2, 2'b01, 0, 0, 0);
    checks++; if (bus.dup_err !== 1'b1) begin errors++; $display("FAIL dup_pulse got %b want 1", bus.dup_err); end
    step(1, 0, 2'b11, 0, 0, 0);
    checks++; if (bus.dup_err !== 1'b0) begin errors++; $display("FAIL dup_once got %b want 0", bus.dup_err); end
    step(1, 1, 2'b11, 0, 0, 0);
    step(1, 3, 2'b11, 0, 0, 0);
    checks++; if (bus.out_ballots !== 8'b11_10_11_11) begin errors++; $display("FAIL dup_ballots got %b want 11101111", bus.out_ballots); end
    checks++; if (bus.out_voted_mask !== 4'b1111) begin errors++; $display("FAIL dup_mask got %b want 1111", bus.out_voted_mask); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_close_partial();
    step(1, 1, 2'b11, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL close_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_ballots !== 8'b00_00_11_00) begin errors++; $display("FAIL close_ballots got %b want 00001100", bus.out_ballots); end
    checks++; if (bus.out_voted_mask !== 4'b0010) begin errors++; $display("FAIL close_mask got %b want 0010", bus.out_voted_mask); end
`ifdef VOTING_ROUND_SEQ_EN
    checks++; if (bus.round_partial !== 1'b1) begin errors++; $display("FAIL close_partial got %b want 1", bus.round_partial); end
`endif
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.out_voted_mask !== 4'b0010) begin errors++; $display("FAIL close_ignored got %b want 0010", bus.out_voted_mask); end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    checks++; if ({bus.out_valid, bus.out_ballots, bus.out_voted_mask} !== 13'h1000) begin errors++; $display("FAIL close_empty got %h want 1000", {bus.out_valid, bus.out_ballots, bus.out_voted_mask}); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_back_pressure();
    step(1, 0, 2'b10, 0, 0, 0);
    step(1, 1, 2'b01, 0, 0, 0);
    step(1, 2, 2'b11, 0, 0, 0);
    step(1, 3, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 2'b01, 0, 0, 0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
      checks++; if (bus.out_ballots !== 8'b00_11_01_10) begin errors++; $display("FAIL bp_stable cyc %0d got %b want 00110110", i, bus.out_ballots); end
    end
    step(1, 0, 2'b01, 0, 1, 0);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
    step(1, 0, 2'b01, 1, 0, 0);
    checks++; if (bus.out_voted_mask !== 4'b0001) begin errors++; $display("FAIL bp_new_mask got %b want 0001", bus.out_voted_mask); end
    checks++; if (bus.out_ballots !== 8'b00_00_00_01) begin errors++; $display("FAIL bp_new_ballots got %b want 00000001", bus.out_ballots); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    step(1, 0, 2'b11, 0, 0, 0);
    step(1, 1, 2'b11, 0, 0, 0);
    step(1, 3, 2'b11, 0, 0, 0);
    step(1, 2, 2'b10, 1, 1, 1);
    checks++; if ({bus.in_ready, bus.out_valid, bus.dup_err} !== 3'b100) begin errors++; $display("FAIL mrst_ctrl got %b want 100", {bus.in_ready, bus.out_valid, bus.dup_err}); end
    checks++; if ({bus.out_ballots, bus.out_voted_mask} !== 12'h000) begin errors++; $display("FAIL mrst_data got %h want 000", {bus.out_ballots, bus.out_voted_mask}); end
    step(1, 2, 2'b01, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.out_voted_mask !== 4'b0100) begin errors++; $display("FAIL mrst_mask got %b want 0100", bus.out_voted_mask); end
    checks++; if (bus.out_ballots !== 8'b00_01_00_00) begin errors++; $display("FAIL mrst_ballots got %b want 00010000", bus.out_ballots); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic v, cl, ordy, r;
    logic [1:0] id, ch;
    for (int i = 0; i < 1500; i++) begin
      v    = 1'($urandom_range(0, 3) != 0);
      id   = 2'($urandom_range(0, 3));
      ch   = 2'($urandom_range(0, 3));
      cl   = 1'($urandom_range(0, 9) == 0);
      ordy = 1'($urandom_range(0, 1));
      r    = 1'($urandom_range(0, 79) == 0);
      step(v, id, ch, cl, ordy, r);
      checks++;
      if (bus.in_ready !== !m_present || bus.out_valid !== m_present || bus.dup_err !== m_dup ||
          bus.out_ballots !== exp_word() || bus.out_voted_mask !== exp_mask()) begin
        errors++;
        $display("FAIL rand cyc %0d got rdy %b vld %b dup %b w %b m %b want rdy %b vld %b dup %b w %b m %b",
                 i, bus.in_ready, bus.out_valid, bus.dup_err, bus.out_ballots, bus.out_voted_mask,
                 !m_present, m_present, m_dup, exp_word(), exp_mask());
      end
`ifdef VOTING_ROUND_SEQ_EN
      checks++;
      if (bus.round_seq !== 8'(m_seq) || bus.round_partial !== 1'(m_present && !all_voted())) begin
        errors++;
        $display("FAIL rand_seq cyc %0d got seq %0d part %b want seq %0d part %b",
                 i, bus.round_seq, bus.round_partial, m_seq, m_present && !all_voted());
      end
`endif
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

`ifdef VOTING_ROUND_SEQ_EN
  task automatic test_round_seq();
    logic [7:0] want;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 257; i++) begin
      want = 8'(i % 256);
      for (int k = 0; k < NV; k++) step(1, 2'(k), 2'($urandom_range(0, 3)), 0, 1, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.round_seq !== want || bus.round_partial !== 1'b0) begin
        errors++;
        $display("FAIL seq round %0d got vld %b seq %0d part %b want 1 %0d 0", i, bus.out_valid, bus.round_seq, bus.round_partial, want);
      end
      step(0, 0, 0, 0, 1, 0);
    end
  endtask
`endif

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_voter_id = '0;
    bus.in_choice   = '0;
    bus.close_req   = 1'b0;
    bus.out_ready   = 1'b0;
    clear_round();
    m_dup = 1'b0;
    m_seq = 0;
    test_reset();
    test_full_round();
    test_duplicate();
    test_close_partial();
    test_back_pressure();
    test_mid_reset();
    test_random();
`ifdef VOTING_ROUND_SEQ_EN
    test_round_seq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
